weight_dot_engine: RTL

- Row-sequencing dot-product engine directly downstream of the weight-row mux.
- Drives the mux Select port with a row index and consumes the selected packed weight row (N_IN signed weights).
- Multiply-accumulates that row serially against a latched feature vector, then emits one neuron result per row, with backpressure.
- Sits between the weight bank/mux and the activation/argmax stage of the classifier.

---
 rtl/weight_dot_pkg.sv | 26 ++
 rtl/weight_dot_if.sv | 23 ++
 rtl/weight_dot_mac.sv | 31 +++
 rtl/weight_dot_engine.sv | 115 +++++++++++
 4 files changed

// File: rtl/weight_dot_pkg.sv
// Shared widths, FSM state type and packed-vector element helpers for the weight dot-product engine.
// Optional build macro WEIGHT_DOT_RELU_EN is consumed by weight_dot_engine.
package weight_dot_pkg;

   localparam int N_IN     = 28;
   localparam int N_OUT    = 28;
   localparam int W_BITS   = 19;
   localparam int X_BITS   = 19;
   localparam int SEL_BIT  = 5;
   localparam int ACC_BITS = 43;
   localparam int K_BITS   = $clog2(N_IN);
   localparam int P_BITS   = W_BITS + X_BITS;

   typedef enum logic [1:0] {IDLE, MAC, OUT, FIN} state_t;

   function automatic logic signed [X_BITS-1:0] get_feat(input logic [N_IN*X_BITS-1:0] v,
                                                        input logic [K_BITS-1:0]      k);
      return v[k*X_BITS +: X_BITS];
   endfunction

   function automatic logic signed [W_BITS-1:0] get_weight(input logic [N_IN*W_BITS-1:0] v,
                                                          input logic [K_BITS-1:0]      k);
      return v[k*W_BITS +: W_BITS];
   endfunction

endpackage

// File: rtl/weight_dot_if.sv
// Bus between the engine, the weight-row mux and the downstream activation stage.
// master = surrounding environment, slave = weight_dot_engine.
interface weight_dot_if;
   import weight_dot_pkg::*;

   logic                        Start;
   logic [N_IN*X_BITS-1:0]      Feature;
   logic [N_IN*W_BITS-1:0]      WeightRow;
   logic [SEL_BIT-1:0]          Select;
   logic                        Busy;
   logic                        ResultValid;
   logic                        ResultReady;
   logic signed [ACC_BITS-1:0]  Result;
   logic [SEL_BIT-1:0]          ResultIdx;
   logic                        Done;

   modport master (output Start, Feature, WeightRow, ResultReady,
                   input  Select, Busy, ResultValid, Result, ResultIdx, Done);

   modport slave  (input  Start, Feature, WeightRow, ResultReady,
                   output Select, Busy, ResultValid, Result, ResultIdx, Done);

endinterface

// File: rtl/weight_dot_mac.sv
// Serial signed multiply-accumulate: full-precision product added into a wide accumulator.
// acc_next is exposed so the final element of a row can be captured without an extra cycle.
module weight_dot_mac
   import weight_dot_pkg::*;
(
   input  logic                       Clk,
   input  logic                       Rst_n,
   input  logic                       clr,
   input  logic                       en,
   input  logic signed [X_BITS-1:0]   x,
   input  logic signed [W_BITS-1:0]   w,
   output logic signed [ACC_BITS-1:0] acc_next
);

   logic signed [P_BITS-1:0]   prod;
   logic signed [ACC_BITS-1:0] acc;

   assign prod     = x * w;
   assign acc_next = acc + ACC_BITS'(prod);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc_next;
      end
   end

endmodule

// File: rtl/weight_dot_engine.sv
// Row-sequencing dot-product engine: selects weight rows, MACs them against a latched feature
// vector and emits one result per row with valid/ready. Define WEIGHT_DOT_RELU_EN to clamp negatives.
module weight_dot_engine
   import weight_dot_pkg::*;
(
   input logic         Clk,
   input logic         Rst_n,
   weight_dot_if.slave bus
);

   state_t                     state_q, state_d;
   logic [SEL_BIT-1:0]         sel_q;
   logic [K_BITS-1:0]          k_q;
   logic [N_IN*X_BITS-1:0]     feat_q;
   logic                       busy_q, rv_q, done_q;
   logic signed [ACC_BITS-1:0] result_q;
   logic [SEL_BIT-1:0]         idx_q;
   logic                       mac_clr, mac_en, last_k, last_row;
   logic signed [ACC_BITS-1:0] acc_next;

   function automatic logic signed [ACC_BITS-1:0] load_result(input logic signed [ACC_BITS-1:0] v);
`ifdef WEIGHT_DOT_RELU_EN
      return v[ACC_BITS-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   assign last_k   = (k_q == K_BITS'(N_IN - 1));
   assign last_row = (sel_q == SEL_BIT'(N_OUT - 1));

   weight_dot_mac u_mac (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .clr      (mac_clr),
      .en       (mac_en),
      .x        (get_feat(feat_q, k_q)),
      .w        (get_weight(bus.WeightRow, k_q)),
      .acc_next (acc_next)
   );

   always_comb begin
      state_d = state_q;
      mac_clr = 1'b0;
      mac_en  = 1'b0;
      case (state_q)
         IDLE: if (bus.Start) begin
            state_d = MAC;
            mac_clr = 1'b1;
         end
         MAC: begin
            mac_en = 1'b1;
            if (last_k) state_d = OUT;
         end
         OUT: if (bus.ResultReady) begin
            mac_clr = 1'b1;
            state_d = last_row ? FIN : MAC;
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         k_q      <= '0;
         feat_q   <= '0;
         busy_q   <= 1'b0;
         rv_q     <= 1'b0;
         result_q <= '0;
         idx_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == FIN);
         case (state_q)
            IDLE: if (bus.Start) begin
               feat_q <= bus.Feature;
               sel_q  <= '0;
               k_q    <= '0;
               busy_q <= 1'b1;
            end
            MAC: begin
               if (last_k) begin
                  result_q <= load_result(acc_next);
                  idx_q    <= sel_q;
                  rv_q     <= 1'b1;
               end else begin
                  k_q <= k_q + 1'b1;
               end
            end
            OUT: if (bus.ResultReady) begin
               rv_q <= 1'b0;
               k_q  <= '0;
               if (!last_row) sel_q <= sel_q + 1'b1;
            end
            FIN: begin
               busy_q <= 1'b0;
               sel_q  <= '0;
            end
            default: ;
         endcase
      end
   end

   assign bus.Select      = sel_q;
   assign bus.Busy        = busy_q;
   assign bus.ResultValid = rv_q;
   assign bus.Result      = result_q;
   assign bus.ResultIdx   = idx_q;
   assign bus.Done        = done_q;

endmodule
